// File: rtl/boot_pkg.sv
// boot_pkg: shared state encodings and byte/word constants for the boot loader.
// S_CHK exists only when BOOT_CHECKSUM_EN is defined.
package boot_pkg;

    localparam int BYTES_PER_WORD = 2;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_WORD_HI,
        S_WORD_LO,
`ifdef BOOT_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERROR
    } boot_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: RAM port B write bus driven by the boot loader.
interface boot_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);

    logic [ADDR_WIDTH-1:0] RamAddr;
    logic [DATA_WIDTH-1:0] RamData;
    logic                  RamWe;

    modport master (
        output RamAddr,
        output RamData,
        output RamWe
    );

    modport slave (
        input RamAddr,
        input RamData,
        input RamWe
    );

endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchronizer and mid-bit sampling.
// Emits one-cycle start, valid and framing-error strobes.
module uart_rx
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      ferr,
    output logic                      start
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);

    rx_state_e st, st_n;

    logic                      rx_s1, rx_s2, rx_d;
    logic [CW-1:0]             cnt;
    logic [BW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      fall, tick_half, tick_full;

    assign fall      = rx_d & ~rx_s2;
    assign tick_half = (cnt == CW'(CLKS_PER_BIT / 2));
    assign tick_full = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= RX_IDLE;
        else        st <= st_n;
    end

    always_comb begin
        st_n = st;
        unique case (st)
            RX_IDLE:  if (fall) st_n = RX_START;
            RX_START: if (tick_half) st_n = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick_full && bit_idx == BW'(UART_DATA_BITS - 1))
                          st_n = RX_STOP;
            RX_STOP:  if (tick_full) st_n = RX_IDLE;
            default:  st_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_d    <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data    <= '0;
            valid   <= 1'b0;
            ferr    <= 1'b0;
            start   <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
            valid <= 1'b0;
            ferr  <= 1'b0;
            start <= 1'b0;
            // Counter restarts on every state change and every full bit.
            if (st == RX_IDLE || st_n != st || tick_full) cnt <= '0;
            else                                          cnt <= cnt + CW'(1);
            if (st == RX_START && tick_half && !rx_s2) begin
                start   <= 1'b1;
                bit_idx <= '0;
            end
            if (st == RX_DATA && tick_full) begin
                shreg   <= {rx_s2, shreg[UART_DATA_BITS-1:1]};
                bit_idx <= bit_idx + BW'(1);
            end
            if (st == RX_STOP && tick_full) begin
                valid <= 1'b1;
                ferr  <= ~rx_s2;
                data  <= shreg;
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a length-prefixed UART image into RAM port B, holding the CPU in reset.
// Define BOOT_CHECKSUM_EN to require a trailing XOR-of-data-bytes checksum byte.
module boot_loader
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Rx,
    boot_loader_if.master ram,
    output logic          CpuRstN,
    output logic          Busy,
    output logic          Done,
    output logic          Error
);

    localparam logic [31:0] CAP       = 32'd1 << ADDR_WIDTH;
    localparam int          WORD_BITS = BYTES_PER_WORD * UART_DATA_BITS;
`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_e S_TAIL = S_CHK;
`else
    localparam boot_state_e S_TAIL = S_DONE;
`endif

    boot_state_e state, next;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid, rx_ferr, rx_start;
    logic                      byte_ok;
    logic [15:0]               len;
    logic [15:0]               n;
    logic [UART_DATA_BITS-1:0] hi;
    logic [WORD_BITS-1:0]      word;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     data;
    logic                      we;
    logic                      last;
`ifdef BOOT_CHECKSUM_EN
    logic [UART_DATA_BITS-1:0] csum;
`endif

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk  (Clk),
        .rst_n(Rst),
        .rx   (Rx),
        .data (rx_data),
        .valid(rx_valid),
        .ferr (rx_ferr),
        .start(rx_start)
    );

    assign byte_ok = rx_valid & ~rx_ferr;
    assign n       = {len[15:8], rx_data};
    assign word    = {hi, rx_data};
    assign last    = (32'(addr) == 32'(len) - 32'd1);

    assign ram.RamAddr = addr;
    assign ram.RamData = data;
    assign ram.RamWe   = we;
    assign Done        = (state == S_DONE);
    assign Error       = (state == S_ERROR);
    assign CpuRstN     = (state == S_DONE);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= S_LEN_HI;
        else      state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            S_LEN_HI:
                if (rx_valid) next = rx_ferr ? S_ERROR : S_LEN_LO;
            S_LEN_LO:
                if (rx_valid) begin
                    if (rx_ferr)              next = S_ERROR;
                    else if (n == 16'd0)      next = S_TAIL;
                    else if (32'(n) > CAP)    next = S_ERROR;
                    else                      next = S_WORD_HI;
                end
            S_WORD_HI:
                if (rx_valid) next = rx_ferr ? S_ERROR : S_WORD_LO;
            // The last word stays here for its write cycle, then leaves.
            S_WORD_LO:
                if (rx_valid) begin
                    if (rx_ferr)   next = S_ERROR;
                    else if (!last) next = S_WORD_HI;
                end else if (we) begin
                    next = S_TAIL;
                end
`ifdef BOOT_CHECKSUM_EN
            S_CHK:
                if (rx_valid)
                    next = (rx_ferr || rx_data != csum) ? S_ERROR : S_DONE;
`endif
            default: next = state;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            len  <= '0;
            hi   <= '0;
            addr <= '0;
            data <= '0;
            we   <= 1'b0;
            Busy <= 1'b0;
        end else begin
            we <= 1'b0;
            if (we) addr <= addr + ADDR_WIDTH'(1);
            if (byte_ok && state == S_LEN_HI) len[15:8] <= rx_data;
            if (byte_ok && state == S_LEN_LO) len[7:0] <= rx_data;
            if (byte_ok && state == S_WORD_HI) hi <= rx_data;
            if (byte_ok && state == S_WORD_LO) begin
                data <= DATA_WIDTH'(word);
                we   <= 1'b1;
            end
            if (next == S_DONE || next == S_ERROR) Busy <= 1'b0;
            else if (rx_start)                      Busy <= 1'b1;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            csum <= '0;
        end else if (byte_ok && (state == S_WORD_HI || state == S_WORD_LO)) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

endmodule
